// File: rtl/blastn_pkg.sv
// Shared types for the BLASTN ungapped diagonal extension: FSM states, termination
// reasons, beat classification and default widths.
package blastn_pkg;

    localparam int unsigned SCORE_W_DEF = 10;
    localparam int unsigned LEN_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXTEND = 2'd1,
        ST_DONE   = 2'd2
    } ext_state_e;

    typedef enum logic [1:0] {
        RSN_NONE  = 2'b00,
        RSN_XDROP = 2'b01,
        RSN_LAST  = 2'b10,
        RSN_LIMIT = 2'b11
    } reason_e;

    typedef enum logic [1:0] {
        BEAT_MATCH    = 2'd0,
        BEAT_MISMATCH = 2'd1,
        BEAT_GAP      = 2'd2
    } beat_e;

    // q[2] flags an ambiguous/gap query letter, which never counts as a match
    function automatic beat_e classify(input logic [2:0] q, input logic [1:0] s);
        if (q[2])
            return BEAT_GAP;
        if (q[1:0] == s)
            return BEAT_MATCH;
        return BEAT_MISMATCH;
    endfunction

endpackage

// File: rtl/xdrop_tracker.sv
// Tracks the best score seen on the diagonal and its length, and flags an X-drop
// using the post-beat cur and best values.
module xdrop_tracker
    import blastn_pkg::*;
#(
    parameter int unsigned SCORE_W = SCORE_W_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_init,
    input  logic signed [SCORE_W-1:0] i_seed,
    input  logic                      i_upd,
    input  logic signed [SCORE_W-1:0] i_cur_nxt,
    input  logic [LEN_W-1:0]          i_len_nxt,
    input  logic [5:0]                i_xdrop,
    output logic signed [SCORE_W-1:0] o_best,
    output logic [LEN_W-1:0]          o_best_len,
    output logic                      o_drop_c
);

    logic signed [SCORE_W-1:0] r_best;
    logic [LEN_W-1:0]          r_best_len;
    logic                      w_gain;
    logic signed [SCORE_W-1:0] w_best_nxt;
    logic [SCORE_W:0]          w_diff;

    // Strictly greater only, so a tie keeps the earlier (shorter) best
    always_comb begin
        w_gain     = i_cur_nxt > r_best;
        w_best_nxt = w_gain ? i_cur_nxt : r_best;
        w_diff     = {w_best_nxt[SCORE_W-1], w_best_nxt} - {i_cur_nxt[SCORE_W-1], i_cur_nxt};
        o_drop_c   = w_diff > (SCORE_W+1)'(i_xdrop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best     <= '0;
            r_best_len <= '0;
        end else if (i_init) begin
            r_best     <= i_seed;
            r_best_len <= '0;
        end else if (i_upd && w_gain) begin
            r_best     <= i_cur_nxt;
            r_best_len <= i_len_nxt;
        end
    end

    assign o_best     = r_best;
    assign o_best_len = r_best_len;

endmodule

// File: rtl/diag_extend.sv
// Ungapped X-drop extension along one diagonal: consumes letter pairs, keeps a
// saturating running score and reports the best score, its length and the stop cause.
module diag_extend
    import blastn_pkg::*;
#(
    parameter int unsigned SCORE_W = SCORE_W_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [SCORE_W-1:0] seed_score,
    input  logic [1:0]                match,
    input  logic [1:0]                mismatch,
    input  logic [1:0]                gap,
    input  logic [5:0]                xdrop,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                q,
    input  logic [1:0]                s,
    input  logic                      in_last,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic signed [SCORE_W-1:0] best_score,
    output logic [LEN_W-1:0]          best_len,
    output logic [1:0]                reason
);

    localparam int unsigned SW1 = SCORE_W + 1;
    localparam logic signed [SCORE_W-1:0] SAT_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
    localparam logic signed [SCORE_W-1:0] SAT_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

    ext_state_e                r_state;
    logic                      r_in_ready;
    logic                      r_res_valid;
    reason_e                   r_reason;
    logic signed [SCORE_W-1:0] r_cur;
    logic [LEN_W-1:0]          r_len;

    beat_e                     w_kind;
    logic [1:0]                w_mag;
    logic [SW1-1:0]            w_delta;
    logic [SW1-1:0]            w_sum;
    logic signed [SCORE_W-1:0] w_cur_nxt;
    logic [LEN_W-1:0]          w_len_nxt;
    logic                      w_limit;
    logic                      w_beat;
    logic                      w_init;
    logic                      w_drop;

    // Score delta and saturating add; the extra bit makes overflow visible
    always_comb begin
        w_kind = classify(q, s);
        case (w_kind)
            BEAT_MATCH:    w_mag = match;
            BEAT_MISMATCH: w_mag = mismatch;
            default:       w_mag = gap;
        endcase
        w_delta = {{(SCORE_W-1){1'b0}}, w_mag};
        if (w_kind != BEAT_MATCH)
            w_delta = -w_delta;
        w_sum = {r_cur[SCORE_W-1], r_cur} + w_delta;
        if (w_sum[SCORE_W] != w_sum[SCORE_W-1])
            w_cur_nxt = w_sum[SCORE_W] ? SAT_MIN : SAT_MAX;
        else
            w_cur_nxt = w_sum[SCORE_W-1:0];
        w_len_nxt = r_len + LEN_W'(1);
        w_limit   = &w_len_nxt;
        w_beat    = r_in_ready & in_valid;
        w_init    = (r_state == ST_IDLE) & start;
    end

    xdrop_tracker #(
        .SCORE_W (SCORE_W),
        .LEN_W   (LEN_W)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_init     (w_init),
        .i_seed     (seed_score),
        .i_upd      (w_beat),
        .i_cur_nxt  (w_cur_nxt),
        .i_len_nxt  (w_len_nxt),
        .i_xdrop    (xdrop),
        .o_best     (best_score),
        .o_best_len (best_len),
        .o_drop_c   (w_drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_reason    <= RSN_NONE;
            r_cur       <= '0;
            r_len       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_EXTEND;
                        r_in_ready <= 1'b1;
                        r_reason   <= RSN_NONE;
                        r_cur      <= seed_score;
                        r_len      <= '0;
                    end
                end
                ST_EXTEND: begin
                    if (w_beat) begin
                        r_cur <= w_cur_nxt;
                        r_len <= w_len_nxt;
                        if (w_drop || in_last || w_limit) begin
                            r_state     <= ST_DONE;
                            r_in_ready  <= 1'b0;
                            r_res_valid <= 1'b1;
                            if (w_drop)
                                r_reason <= RSN_XDROP;
                            else if (in_last)
                                r_reason <= RSN_LAST;
                            else
                                r_reason <= RSN_LIMIT;
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign res_valid = r_res_valid;
    assign reason    = r_reason;

endmodule
